// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// PHY-side Clause 22 MDIO management responder. Oversamples mdc on clk_clk,
// decodes read/write frames addressed to PHY_ADDR and serves a 32-entry
// register space, driving read data back through mdio_out / mdio_oen.
//
// Optional feature: define MDIO_PREAMBLE_SUPPRESS_EN to accept a start
// delimiter after a single preamble 1 (status bit 6 then reads 1).
//
// Handshake: there is no valid/ready pair on this block. Frame bits are
// qualified only by synchronized mdc rising edges, and wr_valid is a
// one-cycle strobe with no backpressure; wr_addr/wr_data hold until the
// next accepted write.
//
// fsm_state exposes the frame decoder state for checkers and debug.

module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] REG0_DEFAULT = 16'h1140,
    parameter logic [15:0] STATUS_BASE  = 16'h7949
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [2:0]  fsm_state
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] ONES_MIN = 6'd1;
`else
    localparam logic [5:0] ONES_MIN = 6'd32;
`endif
    localparam logic [5:0] ONES_MAX = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  mdc_sync;
    logic [1:0]  mdio_sync;
    logic        mdc_q;
    logic        rise;
    logic        bit_in;

    logic [5:0]  ones;
    logic [4:0]  cnt;
    logic        op_hi;
    logic [3:0]  addr_sr;
    logic        addr_match;
    logic [4:0]  reg_addr;
    logic [4:0]  rd_addr_now;
    logic        ta_first;
    logic        ta_ok;
    logic        drive_rd;
    logic        commit;
    logic [15:0] data_sr;
    logic [15:0] rd_sr;
    logic [15:0] rd_val;
    logic [15:0] status_val;
    logic [15:0] reg0;
    logic [15:0] gp_regs [4:15];

    // Frame bit index 13 completes the register address: the last 4 shifted
    // bits plus the bit being sampled now.
    assign rd_addr_now = {addr_sr, bit_in};
    // op_hi is only meaningful past OP, where invalid opcodes already aborted,
    // so op_hi=1 means a read.
    assign drive_rd    = op_hi & addr_match;
    assign rise        = mdc_sync[1] & ~mdc_q;
    assign bit_in      = mdio_sync[1];
    assign ctrl_reg    = reg0;
    assign fsm_state   = state;

    // Two-flop synchronizers for mdc/mdio plus the mdc edge history; reset to
    // the idle-high level so a released reset never fakes an mdc rise.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mdc_sync  <= 2'b11;
            mdio_sync <= 2'b11;
            mdc_q     <= 1'b1;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_in};
            mdc_q     <= mdc_sync[1];
        end
    end

    // Frame decoder state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the decoder only advances on a detected mdc rise.
    always_comb begin
        state_nxt = state;
        if (rise) begin
            case (state)
                S_IDLE:  if (!bit_in && (ones >= ONES_MIN)) state_nxt = S_ST;
                S_ST:    state_nxt = bit_in ? S_OP : S_IDLE;
                S_OP:    if (cnt == 5'd3) state_nxt = (op_hi != bit_in) ? S_PHYAD : S_IDLE;
                S_PHYAD: if (cnt == 5'd8) state_nxt = S_REGAD;
                S_REGAD: if (cnt == 5'd13) state_nxt = S_TA;
                S_TA:    if (cnt == 5'd15) state_nxt = S_DATA;
                S_DATA:  if (cnt == 5'd31) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status register: link_up on bit 2, bit 6 forced when preamble
    // suppression is advertised.
    always_comb begin
        status_val    = STATUS_BASE;
        status_val[2] = link_up;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        status_val[6] = 1'b1;
`endif
    end

    // Read mux for the address completing at the bit-13 rise.
    always_comb begin
        rd_val = 16'h0000;
        if (rd_addr_now == 5'd0) begin
            rd_val = reg0;
        end else if (rd_addr_now == 5'd1) begin
            rd_val = status_val;
        end else if (rd_addr_now == 5'd2) begin
            rd_val = PHY_ID1;
        end else if (rd_addr_now == 5'd3) begin
            rd_val = PHY_ID2;
        end else if (!rd_addr_now[4]) begin
            rd_val = gp_regs[rd_addr_now[3:0]];
        end
    end

    // Frame datapath: preamble counting, field capture, read-data drive and
    // write commit request. Everything moves only on a detected mdc rise.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ones       <= 6'd0;
            cnt        <= 5'd0;
            op_hi      <= 1'b0;
            addr_sr    <= 4'd0;
            addr_match <= 1'b0;
            reg_addr   <= 5'd0;
            ta_first   <= 1'b0;
            ta_ok      <= 1'b0;
            data_sr    <= 16'h0000;
            rd_sr      <= 16'h0000;
            mdio_out   <= 1'b1;
            mdio_oen   <= 1'b1;
            commit     <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (rise) begin
                if (state != S_IDLE) cnt <= cnt + 5'd1;
                case (state)
                    S_IDLE: begin
                        if (bit_in) begin
                            if (ones < ONES_MAX) ones <= ones + 6'd1;
                        end else begin
                            // Either a start bit or a broken preamble: the
                            // count restarts both ways.
                            ones <= 6'd0;
                            cnt  <= 5'd1;
                        end
                    end
                    S_OP: begin
                        if (cnt == 5'd2) op_hi <= bit_in;
                    end
                    S_PHYAD: begin
                        addr_sr <= {addr_sr[2:0], bit_in};
                        if (cnt == 5'd8) addr_match <= ({addr_sr, bit_in} == PHY_ADDR);
                    end
                    S_REGAD: begin
                        addr_sr <= {addr_sr[2:0], bit_in};
                        if (cnt == 5'd13) begin
                            // Snapshot read data now so a later write cannot
                            // change a read already in flight.
                            reg_addr <= rd_addr_now;
                            rd_sr    <= rd_val;
                        end
                    end
                    S_TA: begin
                        if (cnt == 5'd14) begin
                            ta_first <= bit_in;
                            if (drive_rd) begin
                                mdio_oen <= 1'b0;
                                mdio_out <= 1'b0;
                            end
                        end else begin
                            ta_ok <= ta_first & ~bit_in;
                            if (drive_rd) begin
                                mdio_out <= rd_sr[15];
                                rd_sr    <= {rd_sr[14:0], 1'b0};
                            end
                        end
                    end
                    S_DATA: begin
                        data_sr <= {data_sr[14:0], bit_in};
                        if (cnt == 5'd31) begin
                            mdio_oen <= 1'b1;
                            mdio_out <= 1'b1;
                            commit   <= ~op_hi & addr_match & ta_ok;
                        end else if (drive_rd) begin
                            mdio_out <= rd_sr[15];
                            rd_sr    <= {rd_sr[14:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file and write strobe, one cycle after the final data bit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            reg0     <= REG0_DEFAULT;
            for (int i = 4; i < 16; i++) gp_regs[i] <= 16'h0000;
            wr_valid <= 1'b0;
            wr_addr  <= 5'd0;
            wr_data  <= 16'h0000;
        end else begin
            wr_valid <= commit;
            if (commit) begin
                wr_addr <= reg_addr;
                wr_data <= data_sr;
                if (reg_addr == 5'd0) begin
                    if (data_sr[15]) begin
                        // Soft reset: bit 15 self-clears because the
                        // default value is restored instead of stored.
                        reg0 <= REG0_DEFAULT;
                        for (int i = 4; i < 16; i++) gp_regs[i] <= 16'h0000;
                    end else begin
                        reg0 <= data_sr;
                    end
                end else if (!reg_addr[4] && (reg_addr[3:2] != 2'b00)) begin
                    gp_regs[reg_addr[3:0]] <= data_sr;
                end
            end
        end
    end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

PHY-side Clause 22 MDIO management responder: the far end of the TSE MAC's MDIO master (mdc / mdio_in / mdio_out / mdio_oen). It oversamples MDC on the system clock and decodes read/write frames addressed to its PHY address. It serves a 32-entry register space and drives read data back with tristate control, so the same codebase can bring up the MAC's MDIO driver against an emulated PHY in simulation or on the FPGA.

## Interface
Parameters:
- PHY_ADDR, 5'd0: PHY address this responder answers to.
- PHY_ID1, 16'h0141: read-only value of register 2.
- PHY_ID2, 16'h0CC2: read-only value of register 3.
- REG0_DEFAULT, 16'h1140: reset value of register 0 (control).
- STATUS_BASE, 16'h7949: register 1 value; bit 2 replaced by link_up.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- mdc  in  1  management clock from MAC; asynchronous; frequency ≤ clk_clk/8.
- mdio_in  in  1  MDIO line as seen by this block.
- mdio_out  out  1  MDIO drive value.
- mdio_oen  out  1  output enable, active low (0 = drive mdio_out).
- link_up  in  1  reflected into status register bit 2.
- ctrl_reg  out  16  current register 0 contents.
- wr_valid  out  1  one-cycle pulse on every accepted write.
- wr_addr  out  5  register address of accepted write.
- wr_data  out  16  data of accepted write.

## Operation
- mdc and mdio_in each pass through 2-FF synchronizers. A rising edge is detected when the synced mdc goes 0→1. All frame sampling and drive updates occur only on detected rising edges (rise).
- Frame bit index i counts from the first ST bit: ST 0–1 (=01), OP 2–3 (10 read, 01 write), PHYAD 4–8, REGAD 9–13, TA 14–15, DATA 16–31, MSB first.
- States: IDLE → ST → OP → PHYAD → REGAD → TA → DATA → IDLE.
- IDLE: counts consecutive 1s, saturating at 32. A 0 is a valid ST bit 0 only if the count is ≥32; otherwise the count clears.
- ST bit 1 must be 1; otherwise go to IDLE.
- OP 00 or 11: go to IDLE after bit 3.
- PHYAD ≠ PHY_ADDR: the frame continues to bit 31 with mdio_oen held 1, then IDLE. The register file is untouched.
- Read, address match:
  - At the rise sampling bit 14, drive mdio_oen=0, mdio_out=0.
  - At the rise sampling bit 15+j (j=0..15), drive data bit 15−j.
  - At the rise sampling bit 31, release: mdio_oen=1, mdio_out=1.
- Write, address match:
  - TA bits must be 1,0; otherwise the frame is discarded (runs to bit 31, no update).
  - After bit 31, the register is updated and wr_valid pulses.
- Register map:
  - 0: R/W. Bit 15 is self-clearing soft reset: writing 1 restores registers 0 and 4–15 to reset values, and bit 15 reads 0.
  - 1: R/O, STATUS_BASE with bit 2 = link_up.
  - 2, 3: R/O ID registers.
  - 4–15: R/W, reset 0.
  - 16–31: read 0x0000. Writes are ignored but still pulse wr_valid.
- Read data is latched at the bit-13 rise, so later writes do not alter a read in flight.
- After any frame end or abort, the ones counter restarts from 0. Back-to-back frames therefore need a fresh preamble.

## Timing
- Reset values: mdio_out=1, mdio_oen=1, wr_valid=0, wr_addr=0, wr_data=0, ctrl_reg=REG0_DEFAULT; state IDLE, ones counter 0.
- Drive latency: mdio_out/mdio_oen change exactly 3 clk_clk cycles after the mdc pin rises (2 sync + 1 register).
- Write latency: wr_valid asserts 4 cycles after the bit-31 mdc rise at the pin. The register update is visible on ctrl_reg the same cycle.
- Reset mid-frame: outputs return to reset values immediately (asynchronous), including release of the MDIO line.
- A stalled mdc (no edges) holds state indefinitely; there is no timeout.

## Configuration
- MDIO_PREAMBLE_SUPPRESS_EN:
  - Defined: ST is accepted after ≥1 preceding 1 in IDLE (preamble suppression, 802.3 reg 1 bit 6 behaviour). Status register bit 6 reads 1 regardless of STATUS_BASE.
  - Undefined: 32 ones are required, and bit 6 comes from STATUS_BASE.

## Test plan
- Read reg 2, PHY_ADDR match, 32-bit preamble: mdio_oen low from TA bit 15 through data bit 31; the line shifts 0 then 0x0141 MSB first; released after bit 31.
- Write 0xA5A5 to reg 5, then read reg 5: wr_valid single pulse with wr_addr=5, wr_data=0xA5A5; the read returns 0xA5A5.
- Write 0x8000 to reg 0 after writing reg 4=0x1234: ctrl_reg=0x1140, reg 4 reads 0, reg 0 bit 15 reads 0.
- Frame to PHYAD=PHY_ADDR+1: mdio_oen stays 1 for the whole frame, and wr_valid never asserts.
- Preamble of 31 ones, then a valid read to the correct address: no response without the macro; a normal response with MDIO_PREAMBLE_SUPPRESS_EN.
- Assert reset_reset_n=0 at data bit 20 of a read: mdio_oen=1 immediately; a following valid read of reg 1 with link_up=1 returns 0x794D.
